alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 Parameter OPCODE_LENGTH, default 4, width of the ALU Operation code.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-005 in_valid  input  1  upstream holds a valid instruction.
REQ-006 in_ready  output  1  stage accepts the instruction this cycle.
REQ-007 instr  input  32  RV32I instruction word.
REQ-008 pc  input  DATA_WIDTH  instruction address.
REQ-009 rs1_data, rs2_data  input  DATA_WIDTH  register-file read values.
REQ-010 flush  input  1  discard the held entry and any entry presented this cycle.
REQ-011 out_valid  output  1  registered entry valid toward the ALU.
REQ-012 out_ready  input  1  downstream consumes the entry.
REQ-013 Operation  output  OPCODE_LENGTH  ALU operation code.
REQ-014 SrcA, SrcB  output  DATA_WIDTH  ALU operands.
REQ-015 is_branch, br_invert, illegal  output  1 each  branch flag, branch-sense inversion, unsupported instruction.

Function
REQ-016 Operation encoding SHALL be: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SRL 0101, SLL 0110, SRA 0111, SLT 1000, SLTU 1001, EQ 1010.
REQ-017 The stage SHALL be a single-entry pipeline register; in_ready = !out_valid || out_ready, combinational.
REQ-018 Transfer in SHALL occur when in_valid && in_ready && !flush; registered outputs SHALL appear one cycle later (latency 1).
REQ-019 Transfer out SHALL occur when out_valid && out_ready; without a new transfer in, out_valid SHALL clear next cycle.
REQ-020 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-021 Simultaneous transfer out and transfer in SHALL replace the entry, out_valid staying 1 (full throughput).
REQ-022 flush SHALL clear out_valid next cycle and override any simultaneous transfer in.
REQ-023 OP (0110011): funct3/funct7[5] map to ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; SrcA=rs1_data, SrcB=rs2_data.
REQ-024 OP-IMM (0010011): same map, SUB excluded; SrcB=sign-extended I-immediate; shifts SrcB=zero-extended shamt instr[24:20]; funct7[5] selects SRAI.
REQ-025 LOAD, STORE, JALR: Operation ADD, SrcA=rs1_data, SrcB=I/S/I immediate respectively.
REQ-026 LUI: ADD, SrcA=0, SrcB=U-immediate; AUIPC: ADD, SrcA=pc, SrcB=U-immediate; JAL: ADD, SrcA=pc, SrcB=4.
REQ-027 BRANCH: is_branch=1, SrcA=rs1_data, SrcB=rs2_data; BEQ/BNE->EQ, BLT/BGE->SLT, BLTU/BGEU->SLTU; br_invert=1 for BNE/BGE/BGEU.
REQ-028 Any other opcode, invalid funct3, or OP/shift funct7 other than 0000000/0100000 (as permitted) SHALL set illegal=1, Operation=ADD, SrcA=SrcB=0, is_branch=br_invert=0.
REQ-029 Immediates SHALL sign-extend from instr[31]; U-immediate = {instr[31:12], 12'b0}.

Reset
REQ-030 While rst_n=0 at a rising edge: out_valid=0, Operation=0000, SrcA=SrcB=0, is_branch=br_invert=illegal=0.
REQ-031 Reset mid-operation SHALL drop the held entry; in_ready SHALL be 1 during and after reset.
REQ-032 Reset SHALL take priority over flush and transfer.

Structure
REQ-033 Package alu_pkg SHALL hold the Operation enum (11 codes above) and the RV32I opcode/funct3 constants.
REQ-034 Immediate extraction SHALL be a combinational sub-module imm_gen (instr in, I/S/B/U immediates out).

Verification
REQ-035 instr=0x00310133 (add), rs1_data=5, rs2_data=7, in_valid=1 -> next cycle out_valid=1, Operation=0000, SrcA=5, SrcB=7.
REQ-036 instr=0x4040D093 (srai x1,x1,4), rs1_data=0x80000000 -> Operation=0111, SrcB=4, illegal=0.
REQ-037 bne instr, rs1_data=3, rs2_data=3 -> Operation=1010, is_branch=1, br_invert=1, SrcA=SrcB=3.
REQ-038 Entry held, out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> next entry appears next cycle.
REQ-039 flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0; instr=0x0000007F -> illegal=1, Operation=0000.
REQ-040 rst_n=0 for one edge while out_valid=1 -> out_valid=0, all outputs 0, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU operation codes and
// the RV32I opcode / funct3 / funct7 field values used during decode.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_EQ   = 4'b1010
    } alu_op_e;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // OP / OP-IMM funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // BRANCH funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // LOAD / STORE / JALR funct3
    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Base operation selected by funct3 for OP / OP-IMM (funct7 refinement done by caller)
    function automatic alu_op_e f3_to_op(input logic [2:0] f3);
        case (f3)
            F3_ADD:  return ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate extraction; every immediate is sign-extended from bit 31
// to DATA_WIDTH. The opcode field is not needed here, so only [31:7] enters.
module imm_gen
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:7]           i_instr,
    output logic [DATA_WIDTH-1:0] o_imm_i,
    output logic [DATA_WIDTH-1:0] o_imm_s,
    output logic [DATA_WIDTH-1:0] o_imm_b,
    output logic [DATA_WIDTH-1:0] o_imm_u
);

    logic signed [31:0] w_imm_i;
    logic signed [31:0] w_imm_s;
    logic signed [31:0] w_imm_b;
    logic signed [31:0] w_imm_u;

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};

    assign o_imm_i = DATA_WIDTH'(w_imm_i);
    assign o_imm_s = DATA_WIDTH'(w_imm_s);
    assign o_imm_b = DATA_WIDTH'(w_imm_b);
    assign o_imm_u = DATA_WIDTH'(w_imm_u);

endmodule

// File: rtl/alu_issue_stage.sv
// Single-entry issue register between RV32I decode and the ALU: decodes the
// instruction into ALU operation/operands and holds it under valid/ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    pc,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     is_branch,
    output logic                     br_invert,
    output logic                     illegal
);

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_s;
    logic [DATA_WIDTH-1:0] w_imm_u;
    logic [DATA_WIDTH-1:0] w_shamt;

    alu_op_e               w_op;
    logic [DATA_WIDTH-1:0] w_src_a;
    logic [DATA_WIDTH-1:0] w_src_b;
    logic                  w_br;
    logic                  w_inv;
    logic                  w_ill;

    logic                  w_in_ready;
    logic                  w_take;

    logic                  r_valid;
    alu_op_e               r_op;
    logic [DATA_WIDTH-1:0] r_src_a;
    logic [DATA_WIDTH-1:0] r_src_b;
    logic                  r_br;
    logic                  r_inv;
    logic                  r_ill;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_shamt  = DATA_WIDTH'(instr[24:20]);

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .i_instr (instr[31:7]),
        .o_imm_i (w_imm_i),
        .o_imm_s (w_imm_s),
        .o_imm_b (),
        .o_imm_u (w_imm_u)
    );

    // Instruction decode into ALU operation, operands and flags; illegal forces a neutral entry
    always_comb begin
        w_op    = ALU_ADD;
        w_src_a = '0;
        w_src_b = '0;
        w_br    = 1'b0;
        w_inv   = 1'b0;
        w_ill   = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_src_a = rs1_data;
                w_src_b = rs2_data;
                w_op    = f3_to_op(w_funct3);
                if (w_funct7 == F7_ALT && w_funct3 == F3_ADD)     w_op  = ALU_SUB;
                else if (w_funct7 == F7_ALT && w_funct3 == F3_SR) w_op  = ALU_SRA;
                else if (w_funct7 != F7_BASE)                     w_ill = 1'b1;
            end
            OPC_OP_IMM: begin
                w_src_a = rs1_data;
                w_src_b = w_imm_i;
                w_op    = f3_to_op(w_funct3);
                if (w_funct3 == F3_SLL || w_funct3 == F3_SR) begin
                    w_src_b = w_shamt;
                    if (w_funct7 == F7_ALT && w_funct3 == F3_SR) w_op  = ALU_SRA;
                    else if (w_funct7 != F7_BASE)                w_ill = 1'b1;
                end
            end
            OPC_LOAD: begin
                w_src_a = rs1_data;
                w_src_b = w_imm_i;
                w_ill   = !(w_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
            end
            OPC_STORE: begin
                w_src_a = rs1_data;
                w_src_b = w_imm_s;
                w_ill   = (w_funct3 > F3_SW);
            end
            OPC_JALR: begin
                w_src_a = rs1_data;
                w_src_b = w_imm_i;
                w_ill   = (w_funct3 != F3_JALR);
            end
            OPC_LUI: begin
                w_src_b = w_imm_u;
            end
            OPC_AUIPC: begin
                w_src_a = pc;
                w_src_b = w_imm_u;
            end
            OPC_JAL: begin
                w_src_a = pc;
                w_src_b = DATA_WIDTH'(4);
            end
            OPC_BRANCH: begin
                w_src_a = rs1_data;
                w_src_b = rs2_data;
                w_br    = 1'b1;
                case (w_funct3)
                    F3_BEQ:  w_op = ALU_EQ;
                    F3_BNE:  begin w_op = ALU_EQ;   w_inv = 1'b1; end
                    F3_BLT:  w_op = ALU_SLT;
                    F3_BGE:  begin w_op = ALU_SLT;  w_inv = 1'b1; end
                    F3_BLTU: w_op = ALU_SLTU;
                    F3_BGEU: begin w_op = ALU_SLTU; w_inv = 1'b1; end
                    default: w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_op    = ALU_ADD;
            w_src_a = '0;
            w_src_b = '0;
            w_br    = 1'b0;
            w_inv   = 1'b0;
        end
    end

    // Reset term keeps in_ready high while rst_n is low, before the held entry is cleared
    assign w_in_ready = !rst_n || !r_valid || out_ready;
    assign w_take     = in_valid && w_in_ready && !flush;

    // Pipeline register: reset beats flush, flush beats transfer in, otherwise drain on out_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_op    <= ALU_ADD;
            r_src_a <= '0;
            r_src_b <= '0;
            r_br    <= 1'b0;
            r_inv   <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            if (flush)          r_valid <= 1'b0;
            else if (w_take)    r_valid <= 1'b1;
            else if (out_ready) r_valid <= 1'b0;
            if (w_take) begin
                r_op    <= w_op;
                r_src_a <= w_src_a;
                r_src_b <= w_src_b;
                r_br    <= w_br;
                r_inv   <= w_inv;
                r_ill   <= w_ill;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign Operation = OPCODE_LENGTH'(r_op);
    assign SrcA      = r_src_a;
    assign SrcB      = r_src_b;
    assign is_branch = r_br;
    assign br_invert = r_inv;
    assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: stimulus pushes expected entries,
// a negedge monitor compares them against the DUT whenever out_valid is high.
module tb_alu_issue_stage;

    localparam int DW = 32;
    localparam int OL = 4;

    localparam logic [3:0] E_ADD  = 4'd0;
    localparam logic [3:0] E_SUB  = 4'd1;
    localparam logic [3:0] E_XOR  = 4'd2;
    localparam logic [3:0] E_OR   = 4'd3;
    localparam logic [3:0] E_AND  = 4'd4;
    localparam logic [3:0] E_SRL  = 4'd5;
    localparam logic [3:0] E_SLL  = 4'd6;
    localparam logic [3:0] E_SRA  = 4'd7;
    localparam logic [3:0] E_SLT  = 4'd8;
    localparam logic [3:0] E_SLTU = 4'd9;
    localparam logic [3:0] E_EQ   = 4'd10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [OL-1:0] Operation;
    logic [DW-1:0] SrcA;
    logic [DW-1:0] SrcB;
    logic          is_branch;
    logic          br_invert;
    logic          illegal;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic        inv;
        logic        ill;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(
        .DATA_WIDTH    (DW),
        .OPCODE_LENGTH (OL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .is_branch (is_branch),
        .br_invert (br_invert),
        .illegal   (illegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic br, input logic inv, input logic ill);
        exp_t r;
        r.op = op; r.a = a; r.b = b; r.br = br; r.inv = inv; r.ill = ill;
        return r;
    endfunction

    // Monitor: the held entry is always at the queue front; it leaves on consume, flush or reset
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("out_valid_unexpected", 64'(out_valid), 64'd0);
            end else begin
                check("Operation", 64'(Operation), 64'(sbq[0].op));
                check("SrcA",      64'(SrcA),      64'(sbq[0].a));
                check("SrcB",      64'(SrcB),      64'(sbq[0].b));
                check("is_branch", 64'(is_branch), 64'(sbq[0].br));
                check("br_invert", 64'(br_invert), 64'(sbq[0].inv));
                check("illegal",   64'(illegal),   64'(sbq[0].ill));
                if (out_ready === 1'b1 || flush === 1'b1 || rst_n === 1'b0)
                    void'(sbq.pop_front());
            end
        end
    end

    // Drive one cycle of inputs; record the expectation if the stage will accept it
    task automatic apply(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, input logic fl, input logic rst, input exp_t e);
        in_valid = iv; instr = ins; pc = p; rs1_data = a; rs2_data = b;
        out_ready = ordy; flush = fl; rst_n = rst;
        #3;
        if (iv && in_ready === 1'b1 && !fl && rst) sbq.push_back(e);
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    function automatic logic legal_opc(input logic [6:0] o);
        return o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h63};
    endfunction

    // Reference model: pick an instruction class, encode it, and state its ALU-side meaning
    task automatic gen(input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ins, output exp_t e);
        int unsigned k, sel, imm, sh, u;
        int          simm;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [3:0]  op;
        logic        inv;
        ins  = $urandom();
        imm  = $urandom_range(0, 4095);
        simm = (imm >= 2048) ? int'(imm) - 4096 : int'(imm);
        u    = $urandom_range(0, 20'hFFFFF);
        k    = $urandom_range(0, 10);
        f3 = 3'd0; f7 = 7'd0; op = E_ADD; inv = 1'b0;
        e = mk(E_ADD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        case (k)
            0: begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0: begin f3 = 3'd0; f7 = 7'h00; op = E_ADD;  end
                    1: begin f3 = 3'd0; f7 = 7'h20; op = E_SUB;  end
                    2: begin f3 = 3'd1; f7 = 7'h00; op = E_SLL;  end
                    3: begin f3 = 3'd2; f7 = 7'h00; op = E_SLT;  end
                    4: begin f3 = 3'd3; f7 = 7'h00; op = E_SLTU; end
                    5: begin f3 = 3'd4; f7 = 7'h00; op = E_XOR;  end
                    6: begin f3 = 3'd5; f7 = 7'h00; op = E_SRL;  end
                    7: begin f3 = 3'd5; f7 = 7'h20; op = E_SRA;  end
                    8: begin f3 = 3'd6; f7 = 7'h00; op = E_OR;   end
                    default: begin f3 = 3'd7; f7 = 7'h00; op = E_AND; end
                endcase
                ins[6:0] = 7'h33; ins[14:12] = f3; ins[31:25] = f7;
                e = mk(op, a, b, 1'b0, 1'b0, 1'b0);
            end
            1: begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: begin f3 = 3'd0; op = E_ADD;  end
                    1: begin f3 = 3'd2; op = E_SLT;  end
                    2: begin f3 = 3'd3; op = E_SLTU; end
                    3: begin f3 = 3'd4; op = E_XOR;  end
                    4: begin f3 = 3'd6; op = E_OR;   end
                    default: begin f3 = 3'd7; op = E_AND; end
                endcase
                ins[6:0] = 7'h13; ins[14:12] = f3; ins[31:20] = imm[11:0];
                e = mk(op, a, 32'(simm), 1'b0, 1'b0, 1'b0);
            end
            2: begin
                sel = $urandom_range(0, 2);
                sh  = $urandom_range(0, 31);
                case (sel)
                    0: begin f3 = 3'd1; f7 = 7'h00; op = E_SLL; end
                    1: begin f3 = 3'd5; f7 = 7'h00; op = E_SRL; end
                    default: begin f3 = 3'd5; f7 = 7'h20; op = E_SRA; end
                endcase
                ins[6:0] = 7'h13; ins[14:12] = f3; ins[24:20] = sh[4:0]; ins[31:25] = f7;
                e = mk(op, a, 32'(sh), 1'b0, 1'b0, 1'b0);
            end
            3: begin
                sel = $urandom_range(0, 4);
                f3  = (sel < 3) ? 3'(sel) : 3'(sel + 1);
                ins[6:0] = 7'h03; ins[14:12] = f3; ins[31:20] = imm[11:0];
                e = mk(E_ADD, a, 32'(simm), 1'b0, 1'b0, 1'b0);
            end
            4: begin
                f3 = 3'($urandom_range(0, 2));
                ins[6:0] = 7'h23; ins[14:12] = f3; ins[31:25] = imm[11:5]; ins[11:7] = imm[4:0];
                e = mk(E_ADD, a, 32'(simm), 1'b0, 1'b0, 1'b0);
            end
            5: begin
                ins[6:0] = 7'h67; ins[14:12] = 3'd0; ins[31:20] = imm[11:0];
                e = mk(E_ADD, a, 32'(simm), 1'b0, 1'b0, 1'b0);
            end
            6: begin
                ins[6:0] = 7'h37; ins[31:12] = u[19:0];
                e = mk(E_ADD, 32'd0, 32'(u * 4096), 1'b0, 1'b0, 1'b0);
            end
            7: begin
                ins[6:0] = 7'h17; ins[31:12] = u[19:0];
                e = mk(E_ADD, p, 32'(u * 4096), 1'b0, 1'b0, 1'b0);
            end
            8: begin
                ins[6:0] = 7'h6F;
                e = mk(E_ADD, p, 32'd4, 1'b0, 1'b0, 1'b0);
            end
            9: begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: begin f3 = 3'd0; op = E_EQ;   inv = 1'b0; end
                    1: begin f3 = 3'd1; op = E_EQ;   inv = 1'b1; end
                    2: begin f3 = 3'd4; op = E_SLT;  inv = 1'b0; end
                    3: begin f3 = 3'd5; op = E_SLT;  inv = 1'b1; end
                    4: begin f3 = 3'd6; op = E_SLTU; inv = 1'b0; end
                    default: begin f3 = 3'd7; op = E_SLTU; inv = 1'b1; end
                endcase
                ins[6:0] = 7'h63; ins[14:12] = f3;
                e = mk(op, a, b, 1'b1, inv, 1'b0);
            end
            default: begin
                sel = $urandom_range(0, 7);
                case (sel)
                    0: begin
                        do ins[6:0] = 7'($urandom()); while (legal_opc(ins[6:0]));
                    end
                    1: begin
                        ins[6:0] = 7'h33;
                        do f7 = 7'($urandom()); while (f7 == 7'h00 || f7 == 7'h20);
                        ins[31:25] = f7;
                    end
                    2: begin
                        ins[6:0] = 7'h33; ins[31:25] = 7'h20;
                        do f3 = 3'($urandom()); while (f3 == 3'd0 || f3 == 3'd5);
                        ins[14:12] = f3;
                    end
                    3: begin
                        ins[6:0] = 7'h13;
                        if ($urandom_range(0, 1) == 0) begin
                            ins[14:12] = 3'd1;
                            do f7 = 7'($urandom()); while (f7 == 7'h00);
                        end else begin
                            ins[14:12] = 3'd5;
                            do f7 = 7'($urandom()); while (f7 == 7'h00 || f7 == 7'h20);
                        end
                        ins[31:25] = f7;
                    end
                    4: begin ins[6:0] = 7'h63; ins[14:12] = 3'(2 + $urandom_range(0, 1)); end
                    5: begin
                        ins[6:0] = 7'h03;
                        sel = $urandom_range(0, 2);
                        ins[14:12] = (sel == 0) ? 3'd3 : 3'(sel + 5);
                    end
                    6: begin ins[6:0] = 7'h23; ins[14:12] = 3'($urandom_range(4, 7)); end
                    default: begin ins[6:0] = 7'h67; ins[14:12] = 3'($urandom_range(1, 7)); end
                endcase
                e = mk(E_ADD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            end
        endcase
    endtask

    exp_t        idle_e;
    logic [31:0] r_ins;
    exp_t        r_e;
    logic [31:0] r_pc, r_a, r_b;

    initial begin
        idle_e = mk(E_ADD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; pc = '0;
        rs1_data = '0; rs2_data = '0; flush = 1'b0; out_ready = 1'b0;
        edge_wait();
        edge_wait();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_Operation", 64'(Operation), 64'd0);
        check("rst_SrcA",      64'(SrcA),      64'd0);
        check("rst_SrcB",      64'(SrcB),      64'd0);
        check("rst_flags",     64'({is_branch, br_invert, illegal}), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);

        // add x2,x2,x3 with 5 and 7
        apply(1'b1, 32'h00310133, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1,
              mk(E_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0));
        edge_wait();
        check("add_out_valid", 64'(out_valid), 64'd1);

        // srai x1,x1,4
        apply(1'b1, 32'h4040D093, 32'h104, 32'h80000000, 32'd0, 1'b1, 1'b0, 1'b1,
              mk(E_SRA, 32'h80000000, 32'd4, 1'b0, 1'b0, 1'b0));
        edge_wait();
        check("srai_out_valid", 64'(out_valid), 64'd1);

        // bne x1,x2,+8 with equal operands
        apply(1'b1, 32'h00209463, 32'h108, 32'd3, 32'd3, 1'b1, 1'b0, 1'b1,
              mk(E_EQ, 32'd3, 32'd3, 1'b1, 1'b1, 1'b0));
        edge_wait();
        check("bne_out_valid", 64'(out_valid), 64'd1);

        // Backpressure: entry A held for three cycles while B waits
        apply(1'b1, 32'h00310133, 32'h10C, 32'd21, 32'd22, 1'b1, 1'b0, 1'b1,
              mk(E_ADD, 32'd21, 32'd22, 1'b0, 1'b0, 1'b0));
        edge_wait();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'h40310133, 32'h110, 32'd40, 32'd9, 1'b0, 1'b0, 1'b1,
                  mk(E_SUB, 32'd40, 32'd9, 1'b0, 1'b0, 1'b0));
            check("stall_in_ready", 64'(in_ready), 64'd0);
            edge_wait();
            check("stall_out_valid", 64'(out_valid), 64'd1);
        end
        apply(1'b1, 32'h40310133, 32'h110, 32'd40, 32'd9, 1'b1, 1'b0, 1'b1,
              mk(E_SUB, 32'd40, 32'd9, 1'b0, 1'b0, 1'b0));
        edge_wait();
        check("release_out_valid", 64'(out_valid), 64'd1);

        // Flush with a held entry and a simultaneous offer
        apply(1'b1, 32'h00310133, 32'h114, 32'd1, 32'd2, 1'b0, 1'b1, 1'b1, idle_e);
        edge_wait();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        apply(1'b1, 32'h0000007F, 32'h118, 32'h55, 32'h66, 1'b1, 1'b0, 1'b1,
              mk(E_ADD, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1));
        edge_wait();
        check("illegal_out_valid", 64'(out_valid), 64'd1);

        // Reset while an entry is held
        apply(1'b1, 32'h00310133, 32'h11C, 32'd9, 32'd11, 1'b1, 1'b0, 1'b1,
              mk(E_ADD, 32'd9, 32'd11, 1'b0, 1'b0, 1'b0));
        edge_wait();
        apply(1'b0, 32'h00310133, 32'h120, 32'd9, 32'd11, 1'b0, 1'b0, 1'b0, idle_e);
        edge_wait();
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_Operation", 64'(Operation), 64'd0);
        check("mrst_SrcA",      64'(SrcA),      64'd0);
        check("mrst_SrcB",      64'(SrcB),      64'd0);
        check("mrst_flags",     64'({is_branch, br_invert, illegal}), 64'd0);
        check("mrst_in_ready",  64'(in_ready),  64'd1);
        apply(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, idle_e);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        edge_wait();

        // Randomized traffic with backpressure, occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            r_pc = $urandom();
            r_a  = $urandom();
            r_b  = $urandom();
            gen(r_pc, r_a, r_b, r_ins, r_e);
            apply($urandom_range(0, 99) < 75, r_ins, r_pc, r_a, r_b,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
                  !($urandom_range(0, 99) < 2), r_e);
            edge_wait();
        end

        // Drain and confirm nothing is left outstanding
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, idle_e);
            edge_wait();
        end
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_queue", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
